// File: rtl/instr_imm_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : instr_imm_encoder
//  Description : Packs a 32-bit immediate into the I/S/B/J/U fields of an
//                instruction template, flags values that the format cannot
//                represent, and queues the result in a small output FIFO with
//                valid/ready handshakes and a saturating error counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_imm_encoder #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        ImmSel,
    input  logic [31:0]       Imm,
    input  logic [31:0]       Base,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       Instr,
    output logic              out_err,
    output logic [CNT_W-1:0]  err_count
);

    localparam int                 c_ptr_w   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                 c_occ_w   = $clog2(DEPTH + 1);
    localparam logic [c_occ_w-1:0] c_depth   = c_occ_w'(DEPTH);
    localparam logic [c_ptr_w-1:0] c_last    = c_ptr_w'(DEPTH - 1);
    localparam logic [CNT_W-1:0]   c_err_max = '1;

    localparam logic [2:0] c_sel_i = 3'b000;
    localparam logic [2:0] c_sel_s = 3'b001;
    localparam logic [2:0] c_sel_b = 3'b010;
    localparam logic [2:0] c_sel_j = 3'b011;
    localparam logic [2:0] c_sel_u = 3'b100;

    logic [31:0]        r_instr_mem [DEPTH];
    logic [DEPTH-1:0]   r_err_mem;
    logic [c_ptr_w-1:0] r_wptr;
    logic [c_ptr_w-1:0] r_rptr;
    logic [c_occ_w-1:0] r_occ;
    logic [CNT_W-1:0]   r_err_count;

    logic [31:0]        w_instr;
    logic               w_err;
    logic               w_push;
    logic               w_pop;

    // Handshakes depend only on registered occupancy, so out_ready never
    // reaches in_ready combinationally.
    assign in_ready  = (r_occ < c_depth);
    assign out_valid = (r_occ != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;
    assign Instr     = r_instr_mem[r_rptr];
    assign out_err   = r_err_mem[r_rptr];
    assign err_count = r_err_count;

    // Scatter immediate bits into the selected format and check that the
    // value survives the truncation (sign bits equal, alignment for B/J/U).
    always_comb begin
        w_instr = Base;
        w_err   = 1'b0;
        case (ImmSel)
            c_sel_i: begin
                w_instr[31:20] = Imm[11:0];
                w_err          = !((&Imm[31:11]) || !(|Imm[31:11]));
            end
            c_sel_s: begin
                w_instr[31:25] = Imm[11:5];
                w_instr[11:7]  = Imm[4:0];
                w_err          = !((&Imm[31:11]) || !(|Imm[31:11]));
            end
            c_sel_b: begin
                w_instr[31]    = Imm[12];
                w_instr[7]     = Imm[11];
                w_instr[30:25] = Imm[10:5];
                w_instr[11:8]  = Imm[4:1];
                w_err          = Imm[0] || !((&Imm[31:12]) || !(|Imm[31:12]));
            end
            c_sel_j: begin
                w_instr[31]    = Imm[20];
                w_instr[30:21] = Imm[10:1];
                w_instr[20]    = Imm[11];
                w_instr[19:12] = Imm[19:12];
                w_err          = Imm[0] || !((&Imm[31:20]) || !(|Imm[31:20]));
            end
            c_sel_u: begin
                w_instr[31:12] = Imm[31:12];
                w_err          = |Imm[11:0];
            end
            default: begin
                w_err = 1'b1;
            end
        endcase
    end

    // FIFO storage, wrapping pointers, occupancy and saturating error count.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_instr_mem[i] <= '0;
            end
            r_err_mem   <= '0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_occ       <= '0;
            r_err_count <= '0;
        end else begin
            if (w_push) begin
                r_instr_mem[r_wptr] <= w_instr;
                r_err_mem[r_wptr]   <= w_err;
                r_wptr              <= (r_wptr == c_last) ? '0 : r_wptr + 1'b1;
                if (w_err && (r_err_count != c_err_max)) begin
                    r_err_count <= r_err_count + 1'b1;
                end
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == c_last) ? '0 : r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_imm_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_imm_encoder
//  Description : Self-checking bench for instr_imm_encoder: directed format
//                vectors, backpressure, reset and saturation, then randomized
//                traffic against a field-map reference model and decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_imm_encoder;

    localparam int DEPTH   = 2;
    localparam int CNT_W   = 4;
    localparam int ERR_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       ImmSel;
    logic [31:0]      Imm;
    logic [31:0]      Base;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      Instr;
    logic             out_err;
    logic [CNT_W-1:0] err_count;

    typedef struct {
        logic [31:0] instr;
        logic        err;
        logic [2:0]  sel;
        logic [31:0] imm;
    } exp_t;

    exp_t q[$];
    int   ec;
    int   n_tests;
    int   n_fail;

    instr_imm_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ImmSel    (ImmSel),
        .Imm       (Imm),
        .Base      (Base),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Instr     (Instr),
        .out_err   (out_err),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for the whole bench.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Which immediate bit lands in instruction bit p (-1: copied from Base).
    function automatic int src_bit(input logic [2:0] sel, input int p);
        case (sel)
            3'd0: return (p >= 20) ? p - 20 : -1;
            3'd1: begin
                if (p >= 25) return p - 20;
                if (p >= 7 && p <= 11) return p - 7;
                return -1;
            end
            3'd2: begin
                if (p == 31) return 12;
                if (p == 7) return 11;
                if (p >= 25) return p - 20;
                if (p >= 8 && p <= 11) return p - 7;
                return -1;
            end
            3'd3: begin
                if (p == 31) return 20;
                if (p >= 21) return p - 20;
                if (p == 20) return 11;
                if (p >= 12) return p;
                return -1;
            end
            3'd4: return (p >= 12) ? p : -1;
            default: return -1;
        endcase
    endfunction

    // Reference: representable ranges as signed integers, packing by field map.
    function automatic exp_t model(input logic [2:0] sel, input logic [31:0] imm, input logic [31:0] base);
        exp_t   e;
        longint si;
        int     s;
        si      = longint'($signed(imm));
        e.sel   = sel;
        e.imm   = imm;
        e.instr = base;
        for (int p = 0; p < 32; p++) begin
            s = src_bit(sel, p);
            if (s >= 0) e.instr[p] = imm[s];
        end
        case (sel)
            3'd0, 3'd1: e.err = (si < -2048) || (si > 2047);
            3'd2:       e.err = (imm % 2 != 0) || (si < -4096) || (si > 4095);
            3'd3:       e.err = (imm % 2 != 0) || (si < -(64'sd1 << 20)) || (si > (64'sd1 << 20) - 1);
            3'd4:       e.err = (imm % 4096) != 0;
            default:    e.err = 1'b1;
        endcase
        return e;
    endfunction

    // The core's immediate generator, used for the round-trip property.
    function automatic logic [31:0] decode(input logic [31:0] ins, input logic [2:0] sel);
        case (sel)
            3'd0:    return {{20{ins[31]}}, ins[31:20]};
            3'd1:    return {{20{ins[31]}}, ins[31:25], ins[11:7]};
            3'd2:    return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            3'd3:    return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default: return {ins[31:12], 12'b0};
        endcase
    endfunction

    // One clock of stimulus with scoreboard bookkeeping.
    task automatic cycle(input logic v, input logic [2:0] s, input logic [31:0] im,
                         input logic [31:0] b, input logic ordy);
        exp_t e;
        bit   do_push;
        bit   do_pop;
        @(negedge clk);
        in_valid  = v;
        ImmSel    = s;
        Imm       = im;
        Base      = b;
        out_ready = ordy;
        #1;
        check("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
        check("out_valid", 32'(out_valid), 32'(q.size() != 0));
        check("err_count", 32'(err_count), 32'(ec));
        do_push = v && (q.size() < DEPTH);
        do_pop  = ordy && (q.size() != 0);
        if (do_pop) begin
            e = q.pop_front();
            check("instr", Instr, e.instr);
            check("out_err", 32'(out_err), 32'(e.err));
            if (!e.err) check("roundtrip", decode(Instr, e.sel), e.imm);
        end
        if (do_push) begin
            e = model(s, im, b);
            q.push_back(e);
            if (e.err && ec < ERR_MAX) ec++;
        end
    endtask

    // Reset with a request presented during the reset cycle.
    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b1;
        ImmSel   = 3'b111;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        q.delete();
        ec = 0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_err_count", 32'(err_count), 32'd0);
        check("rst_instr", Instr, 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
    endtask

    // Push one request into an empty FIFO, check one-cycle latency and data.
    task automatic directed(input string tag, input logic [2:0] s, input logic [31:0] im,
                            input logic [31:0] b, input logic [31:0] ei, input logic ee);
        cycle(1'b1, s, im, b, 1'b0);
        @(posedge clk);
        #1;
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_instr"}, Instr, ei);
        check({tag, "_err"}, 32'(out_err), 32'(ee));
        cycle(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] im;
        logic [2:0]  s;
        n_tests   = 0;
        n_fail    = 0;
        ec        = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        ImmSel    = 3'd0;
        Imm       = 32'd0;
        Base      = 32'd0;
        out_ready = 1'b0;
        do_reset();

        directed("i_neg1", 3'b000, 32'hFFFF_FFFF, 32'h0000_0093, 32'hFFF0_0093, 1'b0);
        directed("b_8",    3'b010, 32'h0000_0008, 32'h0000_0063, 32'h0000_0463, 1'b0);
        directed("b_9",    3'b010, 32'h0000_0009, 32'h0000_0063, 32'h0000_0463, 1'b1);
        check("b_9_errcnt", 32'(err_count), 32'd1);
        directed("j_800",  3'b011, 32'h0000_0800, 32'h0000_00EF, 32'h0010_00EF, 1'b0);
        directed("u_ok",   3'b100, 32'h1234_5000, 32'h0000_00B7, 32'h1234_50B7, 1'b0);
        directed("u_bad",  3'b100, 32'h1234_5001, 32'h0000_00B7, 32'h1234_50B7, 1'b1);
        directed("i_800",  3'b000, 32'h0000_0800, 32'h0000_0093, 32'h8000_0093, 1'b1);
        directed("illegal",3'b111, 32'h0000_0004, 32'h1234_5678, 32'h1234_5678, 1'b1);

        // Backpressure: three requests, consumer stalled, then drained.
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 3'b000, 32'(i + 1), 32'h0000_0013, 1'b0);
        check("bp_full", 32'(in_ready), 32'd0);
        for (int i = 0; i < 2; i++)
            cycle(1'b1, 3'b000, 32'd3, 32'h0000_0013, 1'b1);
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 3'b000, 32'd0, 32'd0, 1'b1);

        // Reset with two entries queued.
        cycle(1'b1, 3'b001, 32'd5, 32'h0000_0023, 1'b0);
        cycle(1'b1, 3'b001, 32'd6, 32'h0000_0023, 1'b0);
        do_reset();

        // Saturation of the error counter.
        for (int i = 0; i < (1 << CNT_W) + 3; i++)
            cycle(1'b1, 3'b111, 32'(i), 32'h0000_0013, 1'b1);
        cycle(1'b0, 3'b000, 32'd0, 32'd0, 1'b1);
        check("err_sat", 32'(err_count), 32'(ERR_MAX));
        do_reset();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            r = $urandom;
            case ($urandom_range(0, 3))
                0:       im = r;
                1:       im = {{20{r[11]}}, r[11:0]};
                2:       im = {{11{r[20]}}, r[20:1], ($urandom_range(0, 7) == 0)};
                default: im = {r[31:12], 12'b0};
            endcase
            s = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            cycle(1'($urandom_range(0, 1)), s, im, $urandom, 1'($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 4; i++)
            cycle(1'b0, 3'b000, 32'd0, 32'd0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
